// File: rtl/fetch_unit_if.sv
// Fetch stage bus bundle: I-cache request/response plus the
// valid/ready enqueue port toward the instruction queue.
interface fetch_unit_if #(
  parameter int XLEN = 32
);
  logic            imem_read_o;
  logic [XLEN-1:0] imem_addr_o;
  logic            imem_resp_i;
  logic [XLEN-1:0] imem_rdata_i;
  logic            valid_o;
  logic            ready_i;
  logic [XLEN-1:0] pc_o;
  logic [XLEN-1:0] instr_o;
  logic            pred_taken_o;

  modport master (
    output imem_read_o,
    output imem_addr_o,
    input  imem_resp_i,
    input  imem_rdata_i,
    output valid_o,
    input  ready_i,
    output pc_o,
    output instr_o,
    output pred_taken_o
  );

  modport slave (
    input  imem_read_o,
    input  imem_addr_o,
    output imem_resp_i,
    output imem_rdata_i,
    input  valid_o,
    output ready_i,
    input  pc_o,
    input  instr_o,
    input  pred_taken_o
  );
endinterface

// File: rtl/fetch_unit.sv
// Fetch stage: one outstanding I-cache read, 2-entry skid buffer, flush redirect.
// Optional JAL next-PC prediction when FETCH_JAL_PREDICT_EN is defined.
module fetch_unit #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0060
) (
  input  logic            clk_i,
  input  logic            reset_n_i,
  input  logic            flush_i,
  input  logic [XLEN-1:0] flush_pc_i,
  fetch_unit_if.master    bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DROP  = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic [XLEN-1:0] step;
  logic [1:0]      cnt_q, cnt_d;
  logic            head_q, tail_q;
  logic [XLEN-1:0] pc_buf_q    [2];
  logic [XLEN-1:0] instr_buf_q [2];
  logic            push, pop, fits, launch;

  always_comb begin
    push  = (state_q == FETCH) && bus.imem_resp_i && !flush_i;
    pop   = (cnt_q != 2'd0) && bus.ready_i && !flush_i;
    cnt_d = flush_i ? 2'd0
          : cnt_q + {1'b0, push} - {1'b0, pop};
    fits  = (cnt_d <= 2'd1);
  end

`ifdef FETCH_JAL_PREDICT_EN
  logic            is_jal;
  logic [XLEN-1:0] jimm;
  logic            pt_buf_q [2];

  always_comb begin
    is_jal = (bus.imem_rdata_i[6:0] == 7'b1101111);
    jimm   = {{(XLEN-20){bus.imem_rdata_i[31]}},
              bus.imem_rdata_i[19:12],
              bus.imem_rdata_i[20],
              bus.imem_rdata_i[30:21],
              1'b0};
    step   = is_jal ? jimm : XLEN'(4);
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      pt_buf_q[0] <= 1'b0;
      pt_buf_q[1] <= 1'b0;
    end else if (push) begin
      pt_buf_q[tail_q] <= is_jal;
    end
  end

  assign bus.pred_taken_o = pt_buf_q[head_q];
`else
  assign step             = XLEN'(4);
  assign bus.pred_taken_o = 1'b0;
`endif

  always_comb begin
    pc_d = pc_q;
    if (flush_i) begin
      pc_d = {flush_pc_i[XLEN-1:2], 2'b00};
    end else if (push) begin
      pc_d = pc_q + step;
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (!flush_i && fits) state_d = FETCH;
      end
      FETCH: begin
        if (flush_i) begin
          state_d = bus.imem_resp_i ? FETCH : DROP;
        end else if (bus.imem_resp_i) begin
          state_d = fits ? FETCH : IDLE;
        end
      end
      DROP: begin
        if (bus.imem_resp_i) state_d = FETCH;
      end
      default: state_d = IDLE;
    endcase
  end

  // Address latches only when a fresh request starts; DROP keeps the stale one.
  always_comb begin
    launch = (state_d == FETCH) &&
             ((state_q != FETCH) || bus.imem_resp_i);
    addr_d = launch ? pc_d : addr_q;
  end

  always_comb begin
    bus.imem_read_o = (state_q == FETCH) || (state_q == DROP);
    bus.imem_addr_o = addr_q;
    bus.valid_o     = (cnt_q != 2'd0);
    bus.pc_o        = pc_buf_q[head_q];
    bus.instr_o     = instr_buf_q[head_q];
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      pc_q           <= RESET_PC;
      addr_q         <= RESET_PC;
      cnt_q          <= 2'd0;
      head_q         <= 1'b0;
      tail_q         <= 1'b0;
      pc_buf_q[0]    <= '0;
      pc_buf_q[1]    <= '0;
      instr_buf_q[0] <= '0;
      instr_buf_q[1] <= '0;
    end else begin
      pc_q   <= pc_d;
      addr_q <= addr_d;
      cnt_q  <= cnt_d;
      if (flush_i) begin
        head_q <= 1'b0;
        tail_q <= 1'b0;
      end else begin
        if (pop) head_q <= ~head_q;
        if (push) begin
          tail_q              <= ~tail_q;
          pc_buf_q[tail_q]    <= pc_q;
          instr_buf_q[tail_q] <= bus.imem_rdata_i;
        end
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a variable-latency I-cache model.
// Expected PCs and words are hand-derived per scenario.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic [31:0] flush_pc = '0;
  int          lat = 1;
  bit          jal_mode = 1'b0;
  int          wcnt = 0;
  int          pass_n = 0;
  int          total_n = 0;

  fetch_unit_if #(.XLEN(32)) bus ();

  fetch_unit dut (
    .clk_i      (clk),
    .reset_n_i  (rst_n),
    .flush_i    (flush),
    .flush_pc_i (flush_pc),
    .bus        (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] word(input logic [31:0] a);
    if (jal_mode && a == 32'h60) return 32'h0100_006F;
    return {a[23:0], 8'h13};
  endfunction

  initial begin
    bus.imem_resp_i  = 1'b0;
    bus.imem_rdata_i = '0;
    bus.ready_i      = 1'b0;
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      bus.imem_resp_i = 1'b0;
      wcnt = 0;
    end else begin
      bus.imem_resp_i = 1'b0;
      if (bus.imem_read_o) begin
        wcnt++;
        if (wcnt >= lat) begin
          bus.imem_resp_i  = 1'b1;
          bus.imem_rdata_i = word(bus.imem_addr_o);
          wcnt = 0;
        end
      end else begin
        wcnt = 0;
      end
    end
  end

  task automatic do_reset(input int l, input logic rdy);
    rst_n = 1'b0;
    flush = 1'b0;
    lat = l;
    bus.ready_i = rdy;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    total_n++;
    if (bus.valid_o !== 1'b0) $display("FAIL rst_valid got %0b want 0", bus.valid_o);
    else pass_n++;
    total_n++;
    if (bus.imem_read_o !== 1'b0) $display("FAIL rst_read got %0b want 0", bus.imem_read_o);
    else pass_n++;
    total_n++;
    if (bus.pc_o !== 32'h0 || bus.instr_o !== 32'h0)
      $display("FAIL rst_head got %h/%h want 0/0", bus.pc_o, bus.instr_o);
    else pass_n++;
    total_n++;
    if (bus.pred_taken_o !== 1'b0) $display("FAIL rst_pred got %0b want 0", bus.pred_taken_o);
    else pass_n++;
    do_reset(1, 1'b1);
    @(negedge clk);
    total_n++;
    if (bus.imem_read_o !== 1'b1 || bus.imem_addr_o !== 32'h60)
      $display("FAIL rst_first_req got %0b/%h want 1/00000060", bus.imem_read_o, bus.imem_addr_o);
    else pass_n++;
  endtask

  task automatic test_stream();
    do_reset(1, 1'b1);
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      logic [31:0] epc;
      epc = 32'h60 + 32'(4 * i);
      @(negedge clk);
      total_n++;
      if (bus.valid_o !== 1'b1 || bus.pc_o !== epc || bus.instr_o !== word(epc))
        $display("FAIL stream_head%0d got %0b/%h/%h want 1/%h/%h",
                 i, bus.valid_o, bus.pc_o, bus.instr_o, epc, word(epc));
      else pass_n++;
      total_n++;
      if (bus.imem_addr_o !== epc + 32'h4)
        $display("FAIL stream_addr%0d got %h want %h", i, bus.imem_addr_o, epc + 32'h4);
      else pass_n++;
    end
  endtask

  task automatic test_stall();
    int reads;
    reads = 0;
    do_reset(1, 1'b0);
    repeat (3) @(negedge clk);
    for (int i = 3; i <= 10; i++) begin
      if (bus.imem_read_o) reads++;
      if (i != 10) @(negedge clk);
    end
    total_n++;
    if (reads != 0) $display("FAIL stall_reads got %0d want 0", reads);
    else pass_n++;
    total_n++;
    if (bus.valid_o !== 1'b1 || bus.pc_o !== 32'h60 || bus.instr_o !== 32'h0000_6013)
      $display("FAIL stall_head got %0b/%h/%h want 1/00000060/00006013",
               bus.valid_o, bus.pc_o, bus.instr_o);
    else pass_n++;
    bus.ready_i = 1'b1;
    @(negedge clk);
    total_n++;
    if (bus.pc_o !== 32'h64 || bus.imem_read_o !== 1'b1 || bus.imem_addr_o !== 32'h68)
      $display("FAIL stall_resume got %h/%0b/%h want 00000064/1/00000068",
               bus.pc_o, bus.imem_read_o, bus.imem_addr_o);
    else pass_n++;
    @(negedge clk);
    total_n++;
    if (bus.valid_o !== 1'b1 || bus.pc_o !== 32'h68)
      $display("FAIL stall_next got %0b/%h want 1/00000068", bus.valid_o, bus.pc_o);
    else pass_n++;
  endtask

  task automatic test_flush_drop();
    do_reset(4, 1'b1);
    repeat (2) @(negedge clk);
    flush = 1'b1;
    flush_pc = 32'h200;
    @(negedge clk);
    flush = 1'b0;
    total_n++;
    if (bus.imem_read_o !== 1'b1 || bus.imem_addr_o !== 32'h60)
      $display("FAIL drop_addr3 got %0b/%h want 1/00000060", bus.imem_read_o, bus.imem_addr_o);
    else pass_n++;
    @(negedge clk);
    total_n++;
    if (bus.imem_addr_o !== 32'h60) $display("FAIL drop_addr4 got %h want 00000060", bus.imem_addr_o);
    else pass_n++;
    @(negedge clk);
    total_n++;
    if (bus.valid_o !== 1'b0 || bus.imem_addr_o !== 32'h200)
      $display("FAIL drop_redirect got %0b/%h want 0/00000200", bus.valid_o, bus.imem_addr_o);
    else pass_n++;
    repeat (4) @(negedge clk);
    total_n++;
    if (bus.valid_o !== 1'b1 || bus.pc_o !== 32'h200 || bus.instr_o !== 32'h0002_0013)
      $display("FAIL drop_first got %0b/%h/%h want 1/00000200/00020013",
               bus.valid_o, bus.pc_o, bus.instr_o);
    else pass_n++;
  endtask

  task automatic test_flush_with_resp();
    do_reset(1, 1'b1);
    repeat (2) @(negedge clk);
    flush = 1'b1;
    flush_pc = 32'h403;
    @(negedge clk);
    flush = 1'b0;
    total_n++;
    if (bus.valid_o !== 1'b0 || bus.imem_read_o !== 1'b1 || bus.imem_addr_o !== 32'h400)
      $display("FAIL fresp_next got %0b/%0b/%h want 0/1/00000400",
               bus.valid_o, bus.imem_read_o, bus.imem_addr_o);
    else pass_n++;
    @(negedge clk);
    total_n++;
    if (bus.valid_o !== 1'b1 || bus.pc_o !== 32'h400 || bus.instr_o !== 32'h0004_0013)
      $display("FAIL fresp_head got %0b/%h/%h want 1/00000400/00040013",
               bus.valid_o, bus.pc_o, bus.instr_o);
    else pass_n++;
  endtask

  task automatic test_double_flush();
    int bad;
    bad = 0;
    do_reset(4, 1'b1);
    repeat (2) @(negedge clk);
    flush = 1'b1;
    flush_pc = 32'h300;
    @(negedge clk);
    flush_pc = 32'h400;
    @(negedge clk);
    flush = 1'b0;
    for (int i = 5; i <= 8; i++) begin
      @(negedge clk);
      if (bus.imem_addr_o !== 32'h400) bad++;
    end
    total_n++;
    if (bad != 0) $display("FAIL dflush_addr got %0d bad cycles want 0", bad);
    else pass_n++;
    @(negedge clk);
    total_n++;
    if (bus.valid_o !== 1'b1 || bus.pc_o !== 32'h400)
      $display("FAIL dflush_head got %0b/%h want 1/00000400", bus.valid_o, bus.pc_o);
    else pass_n++;
  endtask

  task automatic test_jal();
    logic [31:0] enext;
    logic        epred;
`ifdef FETCH_JAL_PREDICT_EN
    enext = 32'h70;
    epred = 1'b1;
`else
    enext = 32'h64;
    epred = 1'b0;
`endif
    jal_mode = 1'b1;
    do_reset(1, 1'b0);
    repeat (2) @(negedge clk);
    total_n++;
    if (bus.imem_addr_o !== enext) $display("FAIL jal_next got %h want %h", bus.imem_addr_o, enext);
    else pass_n++;
    total_n++;
    if (bus.pc_o !== 32'h60 || bus.instr_o !== 32'h0100_006F || bus.pred_taken_o !== epred)
      $display("FAIL jal_head got %h/%h/%0b want 00000060/0100006f/%0b",
               bus.pc_o, bus.instr_o, bus.pred_taken_o, epred);
    else pass_n++;
    jal_mode = 1'b0;
  endtask

  task automatic test_wrap();
    do_reset(1, 1'b1);
    @(negedge clk);
    flush = 1'b1;
    flush_pc = 32'hFFFF_FFFC;
    @(negedge clk);
    flush = 1'b0;
    total_n++;
    if (bus.imem_addr_o !== 32'hFFFF_FFFC)
      $display("FAIL wrap_addr got %h want fffffffc", bus.imem_addr_o);
    else pass_n++;
    @(negedge clk);
    total_n++;
    if (bus.imem_addr_o !== 32'h0 || bus.pc_o !== 32'hFFFF_FFFC || bus.instr_o !== 32'hFFFF_FC13)
      $display("FAIL wrap_next got %h/%h/%h want 00000000/fffffffc/fffffc13",
               bus.imem_addr_o, bus.pc_o, bus.instr_o);
    else pass_n++;
  endtask

  task automatic test_reset_mid();
    do_reset(4, 1'b1);
    @(negedge clk);
    flush = 1'b1;
    flush_pc = 32'h500;
    @(negedge clk);
    flush = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    total_n++;
    if (bus.imem_read_o !== 1'b0 || bus.valid_o !== 1'b0)
      $display("FAIL rmid_async got %0b/%0b want 0/0", bus.imem_read_o, bus.valid_o);
    else pass_n++;
    do_reset(1, 1'b1);
    @(negedge clk);
    total_n++;
    if (bus.imem_read_o !== 1'b1 || bus.imem_addr_o !== 32'h60)
      $display("FAIL rmid_restart got %0b/%h want 1/00000060", bus.imem_read_o, bus.imem_addr_o);
    else pass_n++;
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_flush_drop();
    test_flush_with_resp();
    test_double_flush();
    test_jal();
    test_wrap();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_n, total_n);
    $finish;
  end

endmodule
